dtw_band_reader: RTL and testbench
==================================

Name: dtw_band_reader

Overview:
- Consumer end of the DTW sample delay-line buffer.
- Drains samples with a one-cycle read strobe, honouring the buffer's empty flag.
- Assembles a sliding window of the R+1 most recent samples.
- Presents one window per sample to the DTW band-cost stage over a valid/ready handshake, for a sequence of programmed length.

Parameters:
- WIDTH, 8, sample width in bits.
- R, 2, band radius; window holds R+1 taps.
- LEN_W, 16, width of the sequence-length and index counters.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- start  input  1  one-cycle pulse; begins a sequence, sampled only in IDLE.
- seq_len  input  LEN_W  number of samples to drain, latched on accepted start.
- src_empty  input  1  buffer has no samples.
- src_data  input  WIDTH  buffer read data, valid the cycle after src_rd.
- src_rd  output  1  one-cycle read strobe to buffer.
- win_valid  output  1  window available.
- win_ready  input  1  downstream accepts window.
- win_data  output  (R+1)*WIDTH  taps packed; tap0 (newest) at [WIDTH-1:0], tap k at [(k+1)*WIDTH-1:k*WIDTH].
- win_idx  output  LEN_W  index of newest sample in window (0-based).
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. All taps, win_idx, sample count and latched length = 0. win_valid, src_rd, busy and done = 0. Applies mid-sequence; any in-flight read is abandoned and its data is not captured.
- FSM states: IDLE, FILL, WAIT, EMIT, DONE.
- IDLE:
  - start=1 with seq_len!=0: latch seq_len, zero all taps, count=0, go to FILL.
  - start=1 with seq_len==0: go to DONE directly, no reads.
- FILL:
  - src_rd = (state==FILL) && !src_empty; combinational from the state register and src_empty.
  - If src_empty=0: go to WAIT. Otherwise hold in FILL with src_rd=0.
- WAIT:
  - Capture src_data: tap0<=src_data, tap[k]<=tap[k-1].
  - win_idx<=count, count<=count+1, go to EMIT.
- EMIT:
  - win_valid=1; win_data and win_idx held stable until handshake.
  - On win_valid&&win_ready: if win_idx==len-1 go to DONE, else go to FILL.
  - win_ready=0: stall indefinitely; no further reads are issued.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy: ignored, including start asserted in the DONE cycle.
- Priming: the first R windows carry zero in the not-yet-filled older taps. Downstream masks them using win_idx<R.
- Latency (empty=0, ready=1 throughout):
  - start sampled at cycle 0; src_rd at cycle 1; capture at cycle 2; win_valid at cycle 3.
  - Steady state: one window per 3 cycles.
- Counters: count and win_idx never exceed len-1; no wrap. seq_len is limited to 2^LEN_W-1 by width.
- win_data is driven from the tap registers at all times, valid only while win_valid=1.

Optional Feature:
- Macro: DTW_BAND_READER_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments on every cycle in FILL with src_empty=1, or in EMIT with win_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst and by each accepted start.
- Undefined: port and logic are absent. Behaviour on all other ports is identical.

Decomposition:
- Shared package dtw_pkg:
  - enum typedef dtw_rd_state_t {IDLE, FILL, WAIT, EMIT, DONE}.
  - Default constants DTW_WIDTH=8, DTW_R=2, DTW_LEN_W=16.
- One natural sub-module, dtw_tap_window: R+1 tap shift register with shift-enable and synchronous clear, exposing the packed taps.
- FSM and counters stay in the top module.

Test Plan:
- Basic drain: reset; buffer holds 5,6,7; start with seq_len=3, ready=1 -> windows {tap0,tap1,tap2} = {5,0,0} idx0, {6,5,0} idx1, {7,6,5} idx2. Exactly 3 src_rd pulses; done one cycle after the last handshake; first win_valid 3 cycles after start.
- Source underflow: start with seq_len=2, src_empty=1 for 4 cycles -> src_rd=0 and no window during the stall. Resumes on empty=0; with STATS_EN, stall_cnt=4.
- Backpressure: win_ready=0 for 5 cycles at idx1 -> win_valid held, win_data and win_idx unchanged, no src_rd. Proceeds one cycle after ready=1.
- Zero length and ignored start: start with seq_len=0 -> done next cycle, no src_rd. A second start pulse during an active seq_len=4 run -> ignored; exactly 4 windows produced.
- Reset mid-operation: rst=1 in the cycle after src_rd -> outputs zero, no capture. A new start with seq_len=1 yields window {next sample,0,0} with idx0.
- Long run: seq_len=1000 random samples with random ready -> window contents match a model shift of the last 3 samples; count of windows = 1000; no src_rd while src_empty=1.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW band reader: reader FSM state encoding
// and default datapath dimensions.
package dtw_pkg;

  localparam int DTW_WIDTH = 8;
  localparam int DTW_R     = 2;
  localparam int DTW_LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } dtw_rd_state_t;

endpackage

// File: rtl/dtw_tap_window.sv
// Sliding window of TAPS samples. tap0 (newest) sits in the low WIDTH bits;
// a shift pushes din into tap0 and moves every older tap up by one slot.
module dtw_tap_window
  import dtw_pkg::*;
#(
  parameter int WIDTH = DTW_WIDTH,
  parameter int TAPS  = DTW_R + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [WIDTH-1:0]      din,
  output logic [TAPS*WIDTH-1:0] taps
);

  logic [TAPS*WIDTH-1:0] taps_q;
  logic [TAPS*WIDTH-1:0] taps_d;
  logic [TAPS*WIDTH-1:0] shifted;

  // A single-tap window degenerates to a plain register.
  generate
    if (TAPS == 1) begin : g_single
      assign shifted = din;
    end else begin : g_multi
      assign shifted = {taps_q[(TAPS-1)*WIDTH-1:0], din};
    end
  endgenerate

  // Next-window selection: clear wins over shift.
  always_comb begin
    taps_d = taps_q;
    if (clr) begin
      taps_d = '0;
    end else if (shift_en) begin
      taps_d = shifted;
    end
  end

  // Tap storage; reset empties the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/dtw_band_reader.sv
// Consumer end of the DTW delay-line buffer. Reads one sample per window
// (FILL issues the strobe, WAIT captures the data returned a cycle later),
// then offers the R+1 newest samples downstream over valid/ready.
// Optional build macro: DTW_BAND_READER_STATS_EN adds a saturating stall
// counter output (stall_cnt).
module dtw_band_reader
  import dtw_pkg::*;
#(
  parameter int WIDTH = DTW_WIDTH,
  parameter int R     = DTW_R,
  parameter int LEN_W = DTW_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       seq_len,
  input  logic                   src_empty,
  input  logic [WIDTH-1:0]       src_data,
  output logic                   src_rd,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [(R+1)*WIDTH-1:0] win_data,
  output logic [LEN_W-1:0]       win_idx,
  output logic                   busy,
  output logic                   done
`ifdef DTW_BAND_READER_STATS_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_FILL = FILL;
  localparam logic [2:0] ST_WAIT = WAIT;
  localparam logic [2:0] ST_EMIT = EMIT;
  localparam logic [2:0] ST_DONE = DONE;

  logic [2:0]       state_q,   state_d;
  logic [LEN_W-1:0] len_q,     len_d;
  logic [LEN_W-1:0] count_q,   count_d;
  logic [LEN_W-1:0] win_idx_q, win_idx_d;
  logic [LEN_W-1:0] last_idx;
  logic             tap_clr;
  logic             tap_shift;

  assign last_idx = len_q - LEN_W'(1);

  // Sequencing: one read, one capture, one window per sample.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    win_idx_d = win_idx_q;
    tap_clr   = 1'b0;
    tap_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (seq_len != '0) begin
            len_d   = seq_len;
            count_d = '0;
            tap_clr = 1'b1;
            state_d = ST_FILL;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FILL: begin
        if (!src_empty) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tap_shift = 1'b1;
        win_idx_d = count_q;
        // Hold at the last index so the counter never passes len-1.
        if (count_q != last_idx) begin
          count_d = count_q + LEN_W'(1);
        end
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (win_ready) begin
          state_d = (win_idx_q == last_idx) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and counters; reset abandons any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      count_q   <= '0;
      win_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      win_idx_q <= win_idx_d;
    end
  end

  dtw_tap_window #(
    .WIDTH (WIDTH),
    .TAPS  (R + 1)
  ) u_taps (
    .clk      (clk),
    .rst      (rst),
    .clr      (tap_clr),
    .shift_en (tap_shift),
    .din      (src_data),
    .taps     (win_data)
  );

  assign src_rd    = (state_q == ST_FILL) && !src_empty;
  assign win_valid = (state_q == ST_EMIT);
  assign win_idx   = win_idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

`ifdef DTW_BAND_READER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cycle;

  // Count cycles lost to an empty source or a stalled consumer.
  always_comb begin
    stall_cycle = ((state_q == ST_FILL) && src_empty) ||
                  ((state_q == ST_EMIT) && !win_ready);
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dtw_band_reader.sv
// Self-checking bench for dtw_band_reader: a table of sequence scenarios
// plus a hand-written mid-sequence reset, all scored against a model that
// rebuilds each expected window from the list of samples read so far.
module tb_dtw_band_reader;

  localparam int W  = 8;
  localparam int R  = 2;
  localparam int LW = 16;
  localparam int TW = (R + 1) * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] seq_len;
  logic          src_empty;
  logic [W-1:0]  src_data;
  logic          src_rd;
  logic          win_valid;
  logic          win_ready;
  logic [TW-1:0] win_data;
  logic [LW-1:0] win_idx;
  logic          busy;
  logic          done;
`ifdef DTW_BAND_READER_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  dtw_band_reader #(
    .WIDTH (W),
    .R     (R),
    .LEN_W (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seq_len   (seq_len),
    .src_empty (src_empty),
    .src_data  (src_data),
    .src_rd    (src_rd),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_idx   (win_idx),
    .busy      (busy),
    .done      (done)
`ifdef DTW_BAND_READER_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    int len;
    int preload;        // 0: keep queue, 1: samples 5,6,7, 2: len random samples
    int empty_stall;    // forced-empty cycles right after start
    int stall_idx;      // window index held off by ready=0 (-1: none)
    int ready_stall;
    bit extra_start;    // pulse start again mid-run and in the DONE cycle
    bit rnd;            // random empty/ready
    int exp_windows;
    int exp_reads;
    int exp_cycles;     // cycle of done relative to start (-1: not checked)
    int exp_first_valid;// -1: never valid, -2: not checked
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] srcq[$];
  logic [W-1:0] seq_samples[$];
  int  win_count, rd_count, hs_cyc, done_cyc, first_valid_cyc, cyc;
  bit  hold_active;
  logic [TW-1:0] hold_data;
  logic [LW-1:0] hold_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected window n: the n-th sample read and the R samples before it.
  function automatic logic [TW-1:0] model_window(input int n);
    logic [TW-1:0] w;
    w = '0;
    for (int k = 0; k <= R; k++) begin
      if (n - k >= 0 && n - k < seq_samples.size()) w[k*W +: W] = seq_samples[n-k];
    end
    return w;
  endfunction

  task automatic new_seq();
    seq_samples.delete();
    win_count       = 0;
    rd_count        = 0;
    hs_cyc          = -1;
    done_cyc        = -1;
    first_valid_cyc = -1;
    cyc             = 0;
    hold_active     = 1'b0;
  endtask

  // Mid-cycle monitor: acts as the buffer and scores handshakes.
  task automatic observe();
    check("rd_while_valid", {63'd0, src_rd & win_valid}, 64'd0);
    if (src_rd) begin
      check("rd_not_empty", {63'd0, src_empty}, 64'd0);
      if (srcq.size() > 0) src_data = srcq.pop_front();
      seq_samples.push_back(src_data);
      rd_count++;
    end
    if (hold_active) begin
      check("hold_valid", {63'd0, win_valid}, 64'd1);
      check("hold_data", {40'd0, win_data}, {40'd0, hold_data});
      check("hold_idx", {48'd0, win_idx}, {48'd0, hold_idx});
    end
    if (win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (win_valid && win_ready) begin
      check("win_data", {40'd0, win_data}, {40'd0, model_window(win_count)});
      check("win_idx", {48'd0, win_idx}, 64'(win_count));
      win_count++;
      hs_cyc = cyc;
    end
    hold_active = win_valid && !win_ready;
    hold_data   = win_data;
    hold_idx    = win_idx;
    if (done) begin
      check("done_once", 64'(done_cyc < 0), 64'd1);
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input vec_t v, input int id);
    int stall_left;
    bit force_empty;
    if (v.preload == 1) begin
      srcq.delete();
      srcq.push_back(8'd5); srcq.push_back(8'd6); srcq.push_back(8'd7);
    end else if (v.preload == 2) begin
      srcq.delete();
      for (int i = 0; i < v.len; i++) srcq.push_back(W'($urandom));
    end
    new_seq();
    stall_left = v.ready_stall;
    while (done_cyc < 0 && cyc < 20000) begin
      start   = (cyc == 0) || (v.extra_start && (cyc == 5 || done));
      seq_len = (cyc == 0) ? LW'(v.len) : LW'(7);
      if (v.rnd) force_empty = ($urandom_range(0, 3) == 0);
      else       force_empty = (cyc >= 1 && cyc <= v.empty_stall);
      src_empty = force_empty || (srcq.size() == 0);
      if (v.rnd) begin
        win_ready = ($urandom_range(0, 9) < 7);
      end else begin
        win_ready = 1'b1;
        if (win_valid && int'(win_idx) == v.stall_idx && stall_left > 0) begin
          win_ready = 1'b0;
          stall_left--;
        end
      end
      check("busy", {63'd0, busy}, 64'(cyc > 0));
      step();
    end
    start = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("windows", 64'(win_count), 64'(v.exp_windows));
    check("reads", 64'(rd_count), 64'(v.exp_reads));
    if (v.exp_cycles >= 0) check("done_cycle", 64'(done_cyc), 64'(v.exp_cycles));
    if (v.exp_first_valid != -2) check("first_valid", 64'(first_valid_cyc), 64'(v.exp_first_valid));
    if (v.len > 0) check("done_after_hs", 64'(done_cyc), 64'(hs_cyc + 1));
`ifdef DTW_BAND_READER_STATS_EN
    begin
      int exp_stall;
      exp_stall = (v.len == 0) ? 0 : done_cyc - 3 * v.len - 1;
      if (exp_stall > 65535) exp_stall = 65535;
      check("stall_cnt", {48'd0, stall_cnt}, 64'(exp_stall));
    end
`endif
    for (int i = 0; i < 2; i++) begin
      src_empty = (srcq.size() == 0);
      win_ready = 1'b1;
      check("idle_busy", {63'd0, busy}, 64'd0);
      check("idle_rd", {63'd0, src_rd}, 64'd0);
      step();
    end
    $display("seq %0d: len=%0d windows=%0d reads=%0d done_cycle=%0d", id, v.len, win_count, rd_count, done_cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t vr;
    //           len  pre emp sidx rst xs rnd  win  rd  cyc  fv
    vecs[0] = '{3,    1,  0,  -1,  0,  0, 0,   3,   3,  10,  3};
    vecs[1] = '{2,    2,  4,  -1,  0,  0, 0,   2,   2,  11,  7};
    vecs[2] = '{3,    2,  0,   1,  5,  0, 0,   3,   3,  15,  3};
    vecs[3] = '{0,    2,  0,  -1,  0,  0, 0,   0,   0,   1, -1};
    vecs[4] = '{4,    2,  0,  -1,  0,  1, 0,   4,   4,  13,  3};
    vecs[5] = '{1000, 2,  0,  -1,  0,  0, 1, 1000, 1000, -1, -2};
    vr      = '{1,    0,  0,  -1,  0,  0, 0,   1,   1,   4,  3};

    cyc = 0;
    rst = 1'b1; start = 1'b0; seq_len = '0; src_empty = 1'b1;
    src_data = '0; win_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_valid", {63'd0, win_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_rd", {63'd0, src_rd}, 64'd0);
    check("rst_data", {40'd0, win_data}, 64'd0);
    check("rst_idx", {48'd0, win_idx}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_seq(vecs[i], i);

    // Reset during the capture cycle: the returned sample must be dropped.
    srcq.delete();
    srcq.push_back(8'hA1);
    srcq.push_back(8'hB2);
    new_seq();
    start = 1'b1; seq_len = LW'(3); src_empty = 1'b0; win_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && rd_count == 0; i++) begin
      src_empty = (srcq.size() == 0);
      step();
    end
    check("mid_rst_read", 64'(rd_count), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {63'd0, win_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_data", {40'd0, win_data}, 64'd0);
    check("mid_rst_idx", {48'd0, win_idx}, 64'd0);
    check("mid_rst_rd", {63'd0, src_rd}, 64'd0);
    $display("seq reset: sample A1 read, reset during capture");
    run_seq(vr, 6);
    check("after_rst_tap0", {56'd0, seq_samples[0]}, 64'hB2);

    run_seq(vecs[5], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
